// File: rtl/seq_alu.sv
// Registered ALU with start/ready/done handshake: 1-cycle ops, W-cycle shift-add multiply.
// Non-MUL results appear one cycle after start; MUL results appear W+1 cycles after start. start is ignored while ready=0.
module seq_alu #(
  parameter int W        = 8,
  parameter int OP_W     = 3,
  parameter int STATUS_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OP_W-1:0]     op,
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  output logic                ready,
  output logic                done,
  output logic [W-1:0]        result,
  output logic [W-1:0]        result_hi,
  output logic [STATUS_W-1:0] status
);

  localparam int CNT_W = $clog2(W);

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SHL = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SHR = OP_W'(7);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [2*W-1:0]   r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_last;

  logic [W:0]       w_sum;
  logic [W-1:0]     w_res;
  logic             w_c;
  logic             w_v;
  logic [3:0]       w_alu_flags;

  logic [2*W-1:0]   w_addend;
  logic [2*W-1:0]   w_prod;
  logic [W-1:0]     w_prod_lo;
  logic [W-1:0]     w_prod_hi;
  logic             w_mul_ovf;
  logic [3:0]       w_mul_flags;

  assign ready    = (r_state != S_MUL);
  assign done     = (r_state == S_DONE);
  assign w_accept = start & ready;
  assign w_is_mul = (op == OP_MUL);
  assign w_last   = (r_cnt == CNT_W'(W - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_is_mul ? S_MUL : S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle ops; flag packing is {V,N,Z,C}
  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      OP_ADD: begin
        w_sum = {1'b0, a} + {1'b0, b};
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (a[W-1] == b[W-1]) && (w_sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        w_sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (a[W-1] != b[W-1]) && (w_sum[W-1] != a[W-1]);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_SHL: begin
        w_res = {a[W-2:0], 1'b0};
        w_c   = a[W-1];
        w_v   = a[W-1] ^ a[W-2];
      end
      OP_SHR: begin
        w_res = {1'b0, a[W-1:1]};
        w_c   = a[0];
      end
      default: begin
        w_res = '0;
      end
    endcase
  end

  assign w_alu_flags = {w_v, w_res[W-1], (w_res == '0), w_c};

  // One shift-add step per cycle on the latched operands
  assign w_addend    = r_a[r_cnt] ? ({{W{1'b0}}, r_b} << r_cnt) : '0;
  assign w_prod      = r_acc + w_addend;
  assign w_prod_lo   = w_prod[W-1:0];
  assign w_prod_hi   = w_prod[2*W-1:W];
  assign w_mul_ovf   = (w_prod_hi != '0);
  assign w_mul_flags = {w_mul_ovf, w_prod_lo[W-1], (w_prod_lo == '0), w_mul_ovf};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      result    <= '0;
      result_hi <= '0;
      status    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_a   <= a;
              r_b   <= b;
              r_acc <= '0;
              r_cnt <= '0;
            end else begin
              result    <= w_res;
              result_hi <= '0;
              status    <= STATUS_W'(w_alu_flags);
            end
          end
        end
        S_MUL: begin
          r_acc <= w_prod;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            result    <= w_prod_lo;
            result_hi <= w_prod_hi;
            status    <= STATUS_W'(w_mul_flags);
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (W=8) with hand-computed results and flags {V,N,Z,C}.
module tb_seq_alu;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       ready;
  logic       done;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic [3:0] status;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(.W(8), .OP_W(3), .STATUS_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .status    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] t_op, input logic [7:0] t_a,
                       input logic [7:0] t_b, input int exp_lat, input logic [7:0] exp_res,
                       input logic [7:0] exp_hi, input logic [3:0] exp_st);
    int cyc;
    int rdy_low;
    @(negedge clk);
    start = 1'b1; op = t_op; a = t_a; b = t_b;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    rdy_low = 0;
    while (!done && cyc < 40) begin
      if (!ready) rdy_low++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " ready_low"}, rdy_low, exp_lat - 1);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " result_hi"}, result_hi, exp_hi);
    chk({tag, " status"}, status, exp_st);
    chk({tag, " ready_in_done"}, ready, 1);
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, done, 0);
  endtask

  initial begin
    int n_done;
    int done_cyc;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", ready, 1);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    chk("rst result_hi", result_hi, 0);
    chk("rst status", status, 0);
    @(negedge clk);
    reset = 1'b0;

    //      tag          op    a      b      lat res    hi     {V,N,Z,C}
    do_op("add_ff_01",  3'd0, 8'hFF, 8'h01, 1, 8'h00, 8'h00, 4'b0011);
    do_op("add_7f_01",  3'd0, 8'h7F, 8'h01, 1, 8'h80, 8'h00, 4'b1100);
    do_op("sub_00_01",  3'd1, 8'h00, 8'h01, 1, 8'hFF, 8'h00, 4'b0100);
    do_op("sub_05_05",  3'd1, 8'h05, 8'h05, 1, 8'h00, 8'h00, 4'b0011);
    do_op("sub_80_01",  3'd1, 8'h80, 8'h01, 1, 8'h7F, 8'h00, 4'b1001);
    do_op("xor_aa_aa",  3'd5, 8'hAA, 8'hAA, 1, 8'h00, 8'h00, 4'b0010);
    do_op("and_f0_3c",  3'd3, 8'hF0, 8'h3C, 1, 8'h30, 8'h00, 4'b0000);
    do_op("or_80_01",   3'd4, 8'h80, 8'h01, 1, 8'h81, 8'h00, 4'b0100);
    do_op("shl_81",     3'd6, 8'h81, 8'h55, 1, 8'h02, 8'h00, 4'b1001);
    do_op("shl_40",     3'd6, 8'h40, 8'h00, 1, 8'h80, 8'h00, 4'b1100);
    do_op("shr_81",     3'd7, 8'h81, 8'hFF, 1, 8'h40, 8'h00, 4'b0001);
    do_op("mul_10_10",  3'd2, 8'h10, 8'h10, 9, 8'h00, 8'h01, 4'b1011);
    do_op("mul_03_05",  3'd2, 8'h03, 8'h05, 9, 8'h0F, 8'h00, 4'b0000);
    do_op("mul_80_02",  3'd2, 8'h80, 8'h02, 9, 8'h00, 8'h01, 4'b1011);

    // Back-to-back: second op launched in the done cycle of the first
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 8'h01; b = 8'h01;
    @(posedge clk); #1;
    chk("b2b first done", done, 1);
    chk("b2b first result", result, 8'h02);
    op = 3'd1; a = 8'h09; b = 8'h02;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b second done", done, 1);
    chk("b2b second result", result, 8'h07);
    chk("b2b second status", status, 4'b0001);
    @(posedge clk); #1;
    chk("b2b done drops", done, 0);

    // MUL FF*FF with an ADD start pulse and operand change in cycle 3
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (cyc == 3) begin
        start = 1'b1; op = 3'd0; a = 8'h01; b = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("mul_ign done_count", n_done, 1);
    chk("mul_ign done_cycle", done_cyc, 9);
    chk("mul_ign result", result, 8'h01);
    chk("mul_ign result_hi", result_hi, 8'hFE);
    chk("mul_ign status", status, 4'b1001);

    // Reset in cycle 4 of a MUL aborts it
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 8'h10; b = 8'h10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort ready_before", ready, 0);
    reset = 1'b1;
    #1;
    chk("abort ready", ready, 1);
    chk("abort done", done, 0);
    chk("abort result", result, 0);
    chk("abort result_hi", result_hi, 0);
    chk("abort status", status, 0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("abort no_done", n_done, 0);
    do_op("add_after_abort", 3'd0, 8'h02, 8'h03, 1, 8'h05, 8'h00, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
